// File: rtl/apb_regbank_pkg.sv
// Shared constants, register map and FSM encoding for the b-side APB register bank.
package apb_regbank_pkg;

  localparam int REG_WD      = 32;
  localparam int REG_STRB_WD = REG_WD / 8;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_XFER  = 4'd1;
  localparam logic [3:0] REG_ERR   = 4'd2;
  localparam logic [3:0] REG_SCR0  = 4'd3;

  localparam int WAIT_LSB    = 0;
  localparam int WAIT_MSB    = 3;
  localparam int WAIT_WD     = WAIT_MSB - WAIT_LSB + 1;
  localparam int PRIV_EN_BIT = 8;

  localparam int ERR_CNT_WD  = 16;
  localparam int NUM_SCRATCH = 13;

  typedef enum logic {IDLE, ACCESS} state_e;

  // Byte-lane merge: lanes with a set strobe take the new data.
  function automatic logic [REG_WD-1:0] apply_strb(input logic [REG_WD-1:0]      old_w,
                                                   input logic [REG_WD-1:0]      new_w,
                                                   input logic [REG_STRB_WD-1:0] strb);
    logic [REG_WD-1:0] res;
    res = old_w;
    for (int i = 0; i < REG_STRB_WD; i++) begin
      if (strb[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_regbank_waitgen.sv
// APB transfer FSM with programmable wait-state counter; produces the completion strobe.
module apb_regbank_waitgen
  import apb_regbank_pkg::*;
(
  input  logic               b_pclk,
  input  logic               b_prst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic [WAIT_WD-1:0] wait_cfg,
  output logic               pready
);

  state_e             state, state_nxt;
  logic [WAIT_WD-1:0] wcnt, wcnt_nxt;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pready    = 1'b0;
    case (state)
      IDLE: begin
        // Wait count is latched at setup so a CTRL.WAIT change never affects an in-flight transfer.
        if (psel && !penable) begin
          state_nxt = ACCESS;
          wcnt_nxt  = wait_cfg;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_nxt = IDLE;
        end else if (penable) begin
          if (wcnt != '0) begin
            wcnt_nxt = wcnt - 1'b1;
          end else begin
            pready    = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/apb_regbank_slave.sv
// b-side APB slave: address decode, byte-strobed 16-word register map, transfer/error counters.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32,
  parameter int STRB_WD = 4,
  parameter int PROT_WD = 3
) (
  input  logic               b_pclk,
  input  logic               b_prst_n,
  input  logic               b_psel,
  input  logic               b_penable,
  input  logic               b_pwrite,
  input  logic [ADDR_WD-1:0] b_paddr,
  input  logic [DATA_WD-1:0] b_pwdata,
  input  logic [PROT_WD-1:0] b_pprot,
  input  logic [STRB_WD-1:0] b_pstrb,
  output logic [DATA_WD-1:0] b_prdata,
  output logic               b_pready,
  output logic               b_pslverr
);

  logic [WAIT_WD-1:0]    ctrl_wait;
  logic                  priv_en;
  logic [DATA_WD-1:0]    xfer_cnt;
  logic [ERR_CNT_WD-1:0] err_cnt;
  logic [DATA_WD-1:0]    scratch [NUM_SCRATCH];

  logic [3:0]         idx;
  logic [3:0]         sidx;
  logic               unaligned;
  logic               err;
  logic [DATA_WD-1:0] rd_word;
  logic [DATA_WD-1:0] wr_word;
  logic               unused_bits;

  assign unused_bits = ^{b_paddr[ADDR_WD-1:6], b_pprot[PROT_WD-1:1]};

  apb_regbank_waitgen u_waitgen (
    .b_pclk   (b_pclk),
    .b_prst_n (b_prst_n),
    .psel     (b_psel),
    .penable  (b_penable),
    .wait_cfg (ctrl_wait),
    .pready   (b_pready)
  );

  assign idx       = b_paddr[5:2];
  assign sidx      = idx - REG_SCR0;
  assign unaligned = |b_paddr[1:0];
  assign err       = unaligned ||
                     (b_pwrite && (idx == REG_XFER || idx == REG_ERR)) ||
                     (b_pwrite && priv_en && !b_pprot[0]);

  always_comb begin
    rd_word = '0;
    case (idx)
      REG_CTRL: begin
        rd_word[WAIT_MSB:WAIT_LSB] = ctrl_wait;
        rd_word[PRIV_EN_BIT]       = priv_en;
      end
      REG_XFER: rd_word = xfer_cnt;
      REG_ERR:  rd_word[ERR_CNT_WD-1:0] = err_cnt;
      default:  rd_word = scratch[sidx];
    endcase
  end

  // rd_word doubles as the old value for the strobe merge on writable registers.
  assign wr_word   = apply_strb(rd_word, b_pwdata, b_pstrb);
  assign b_prdata  = (b_pready && !b_pwrite && !unaligned) ? rd_word : '0;
  assign b_pslverr = b_pready && err;

  always_ff @(posedge b_pclk or negedge b_prst_n) begin
    if (!b_prst_n) begin
      ctrl_wait <= '0;
      priv_en   <= 1'b0;
      xfer_cnt  <= '0;
      err_cnt   <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else if (b_pready) begin
      xfer_cnt <= xfer_cnt + 32'd1;
      if (err) begin
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end else if (b_pwrite) begin
        if (idx == REG_CTRL) begin
          ctrl_wait <= wr_word[WAIT_MSB:WAIT_LSB];
          priv_en   <= wr_word[PRIV_EN_BIT];
        end else if (idx >= REG_SCR0) begin
          scratch[sidx] <= wr_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Randomized + directed bench for apb_regbank_slave against an abstract register-map model.
module tb_apb_regbank_slave;

  logic        b_pclk = 1'b0;
  logic        b_prst_n;
  logic        b_psel, b_penable, b_pwrite;
  logic [31:0] b_paddr, b_pwdata, b_prdata;
  logic [2:0]  b_pprot;
  logic [3:0]  b_pstrb;
  logic        b_pready, b_pslverr;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          m_wait;
  bit          m_priv;
  logic [31:0] m_scr [13];
  logic [31:0] m_xfer;
  int          m_err;

  always #5 b_pclk = ~b_pclk;

  apb_regbank_slave dut (
    .b_pclk    (b_pclk),
    .b_prst_n  (b_prst_n),
    .b_psel    (b_psel),
    .b_penable (b_penable),
    .b_pwrite  (b_pwrite),
    .b_paddr   (b_paddr),
    .b_pwdata  (b_pwdata),
    .b_pprot   (b_pprot),
    .b_pstrb   (b_pstrb),
    .b_prdata  (b_prdata),
    .b_pready  (b_pready),
    .b_pslverr (b_pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_wait = 0;
    m_priv = 0;
    m_xfer = 0;
    m_err  = 0;
    for (int i = 0; i < 13; i++) m_scr[i] = 0;
  endfunction

  function automatic logic [31:0] model_read(input int word);
    case (word)
      0:       return (m_priv ? 32'h100 : 32'h0) + 32'(m_wait);
      1:       return m_xfer;
      2:       return 32'(m_err);
      default: return m_scr[word-3];
    endcase
  endfunction

  // One complete APB transfer; acc = access cycle in which pready appeared (0 = timed out).
  task automatic bus_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata, output logic serr, output int acc);
    bit done = 0;
    acc = 0; rdata = 0; serr = 0;
    @(posedge b_pclk); #1;
    b_psel = 1; b_penable = 0; b_pwrite = wr; b_paddr = addr;
    b_pwdata = data; b_pstrb = strb; b_pprot = prot;
    @(posedge b_pclk); #1;
    b_penable = 1;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge b_pclk);
      if (b_pready) begin
        acc = i; rdata = b_prdata; serr = b_pslverr; done = 1;
      end
      @(posedge b_pclk); #1;
    end
    b_psel = 0; b_penable = 0;
  endtask

  task automatic xfer_chk(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                          output logic [31:0] rdata);
    int          word = int'(addr[5:2]);
    bit          unal = (addr[1:0] != 0);
    bit          e_err;
    logic [31:0] e_rd, cur;
    logic        serr;
    int          acc;
    e_err = unal || (wr && (word == 1 || word == 2)) || (wr && m_priv && !prot[0]);
    e_rd  = wr ? 32'h0 : model_read(word);
    bus_xfer(wr, addr, data, strb, prot, rdata, serr, acc);
    check({tag, "_cycles"}, 32'(acc), 32'(m_wait + 1));
    check({tag, "_slverr"}, {31'b0, serr}, {31'b0, e_err});
    if (!e_err) check({tag, "_rdata"}, rdata, e_rd);
    m_xfer = m_xfer + 1;
    if (e_err) begin
      if (m_err < 65535) m_err++;
    end else if (wr && word != 1 && word != 2) begin
      cur = model_read(word);
      for (int b = 0; b < 4; b++) if (strb[b]) cur[b*8 +: 8] = data[b*8 +: 8];
      if (word == 0) begin
        m_wait = int'(cur[3:0]);
        m_priv = cur[8];
      end else begin
        m_scr[word-3] = cur;
      end
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    b_prst_n = 0; b_psel = 0; b_penable = 0; b_pwrite = 0;
    b_paddr = 0; b_pwdata = 0; b_pprot = 0; b_pstrb = 0;
    model_reset();
    repeat (3) @(posedge b_pclk);
    #1;
    check("rst_pready", {31'b0, b_pready}, 32'h0);
    check("rst_pslverr", {31'b0, b_pslverr}, 32'h0);
    check("rst_prdata", b_prdata, 32'h0);
    b_prst_n = 1;

    xfer_chk("rd_ctrl0", 0, 32'h00, 0, 4'h0, 3'b000, rd);
    check("ctrl0_val", rd, 32'h0);
    xfer_chk("rd_xfer1", 0, 32'h04, 0, 4'h0, 3'b000, rd);
    check("xfer1_val", rd, 32'h1);

    xfer_chk("wr_wait3", 1, 32'h00, 32'h3, 4'hF, 3'b000, rd);
    xfer_chk("wr_scr0", 1, 32'h0C, 32'hDEADBEEF, 4'hF, 3'b000, rd);
    xfer_chk("rd_scr0", 0, 32'h0C, 0, 4'h0, 3'b000, rd);
    check("scr0_full", rd, 32'hDEADBEEF);
    xfer_chk("wr_scr0_strb", 1, 32'h0C, 32'h11223344, 4'b0101, 3'b000, rd);
    xfer_chk("rd_scr0_strb", 0, 32'h0C, 0, 4'h0, 3'b000, rd);
    check("scr0_merge", rd, 32'hDE22BE44);

    xfer_chk("wr_ro_xfer", 1, 32'h04, 32'hFFFFFFFF, 4'hF, 3'b001, rd);
    xfer_chk("wr_unal", 1, 32'h0E, 32'h0, 4'hF, 3'b001, rd);
    xfer_chk("rd_errcnt", 0, 32'h08, 0, 4'h0, 3'b000, rd);
    check("errcnt_two", rd, 32'h2);
    xfer_chk("rd_scr0_keep", 0, 32'h0C, 0, 4'h0, 3'b000, rd);

    xfer_chk("wr_priv", 1, 32'h00, 32'h100, 4'hF, 3'b001, rd);
    xfer_chk("wr_unpriv", 1, 32'h10, 32'h5A, 4'hF, 3'b000, rd);
    xfer_chk("rd_unpriv", 0, 32'h10, 0, 4'h0, 3'b000, rd);
    check("unpriv_blocked", rd, 32'h0);
    xfer_chk("wr_privok", 1, 32'h10, 32'h5A, 4'hF, 3'b001, rd);
    xfer_chk("rd_privok", 0, 32'h10, 0, 4'h0, 3'b000, rd);
    check("priv_write", rd, 32'h5A);
    xfer_chk("wr_nostrb", 1, 32'h10, 32'hFFFFFFFF, 4'h0, 3'b001, rd);
    xfer_chk("rd_nostrb", 0, 32'h10, 0, 4'h0, 3'b000, rd);

    // Abort: WAIT=5, two access cycles, then psel drops
    xfer_chk("wr_wait5", 1, 32'h00, 32'h5, 4'hF, 3'b001, rd);
    @(posedge b_pclk); #1;
    b_psel = 1; b_penable = 0; b_pwrite = 1; b_paddr = 32'h14;
    b_pwdata = 32'hCAFEF00D; b_pstrb = 4'hF; b_pprot = 3'b001;
    @(posedge b_pclk); #1;
    b_penable = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge b_pclk);
      check("abort_no_ready", {31'b0, b_pready}, 32'h0);
      @(posedge b_pclk); #1;
    end
    b_psel = 0; b_penable = 0;
    xfer_chk("rd_xfer_abort", 0, 32'h04, 0, 4'h0, 3'b000, rd);
    xfer_chk("rd_scr_abort", 0, 32'h14, 0, 4'h0, 3'b000, rd);
    check("abort_no_commit", rd, 32'h0);

    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      xfer_chk("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
               3'($urandom), rd);
    end

    // Reset mid-ACCESS
    xfer_chk("wr_wait5b", 1, 32'h00, 32'h105, 4'hF, 3'b001, rd);
    @(posedge b_pclk); #1;
    b_psel = 1; b_penable = 0; b_pwrite = 1; b_paddr = 32'h18;
    b_pwdata = 32'h12345678; b_pstrb = 4'hF; b_pprot = 3'b001;
    @(posedge b_pclk); #1;
    b_penable = 1;
    @(negedge b_pclk);
    check("prereset_no_ready", {31'b0, b_pready}, 32'h0);
    #1 b_prst_n = 0;
    #1;
    check("inrst_pready", {31'b0, b_pready}, 32'h0);
    check("inrst_prdata", b_prdata, 32'h0);
    b_psel = 0; b_penable = 0;
    @(posedge b_pclk); #1;
    b_prst_n = 1;
    model_reset();
    xfer_chk("rd_ctrl_postrst", 0, 32'h00, 0, 4'h0, 3'b000, rd);
    check("ctrl_postrst", rd, 32'h0);
    xfer_chk("rd_scr_postrst", 0, 32'h18, 0, 4'h0, 3'b000, rd);
    xfer_chk("rd_xfer_postrst", 0, 32'h04, 0, 4'h0, 3'b000, rd);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
